// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: opcodes, ALU encodings,
// FSM states, datapath select codes and instruction field helpers.
package ctrl_pkg;

   // Widest instruction word the field helpers accept
   localparam int MAX_W = 64;

   // Opcode values, right-aligned in the opcode field
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDA = 4'h1;
   localparam logic [3:0] OP_STA = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_JC  = 4'hA;
   localparam logic [3:0] OP_LDI = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Operation codes presented to the external ALU
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_WB,
      ST_HALT
   } state_e;

   // Source of the next PC value when the PC is loaded
   typedef enum logic [1:0] {
      PC_ZERO,
      PC_INC,
      PC_JUMP
   } pc_sel_e;

   // Source of the next accumulator value when it is loaded
   typedef enum logic [1:0] {
      ACC_MEM,
      ACC_IMM,
      ACC_ALU
   } acc_sel_e;

   // Opcode field sits at the top of the instruction word
   function automatic logic [MAX_W-1:0] instrOpcode(input logic [MAX_W-1:0] instr,
                                                    input int dataW,
                                                    input int opcW);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << opcW) - MAX_W'(1);
      return (instr >> (dataW - opcW)) & mask;
   endfunction

   // Operand field sits at the bottom of the instruction word
   function automatic logic [MAX_W-1:0] instrOperand(input logic [MAX_W-1:0] instr,
                                                     input int addrW);
      logic [MAX_W-1:0] mask;
      mask = (MAX_W'(1) << addrW) - MAX_W'(1);
      return instr & mask;
   endfunction

   // Maps an arithmetic/logic opcode onto the ALU operation code
   function automatic logic [2:0] aluOpFor(input logic [MAX_W-1:0] opc);
      logic [2:0] op;
      case (opc)
         MAX_W'(OP_SUB): op = ALU_SUB;
         MAX_W'(OP_AND): op = ALU_AND;
         MAX_W'(OP_OR):  op = ALU_OR;
         MAX_W'(OP_XOR): op = ALU_XOR;
         default:        op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ctrl_datapath.sv
// Architectural registers of the controller: PC, IR, accumulator, memory
// data register and Z/C/V flags. All updates are gated by FSM load enables.
module ctrl_datapath
   import ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              pcLoad_i,
   input  logic [1:0]        pcSel_i,
   input  logic [ADDR_W-1:0] jumpAddr_i,
   input  logic              irLoad_i,
   input  logic              mdrLoad_i,
   input  logic              accLoad_i,
   input  logic [1:0]        accSel_i,
   input  logic              flagsLoad_i,
   input  logic [DATA_W-1:0] memRdata_i,
   input  logic [DATA_W-1:0] immValue_i,
   input  logic [DATA_W-1:0] aluResult_i,
   input  logic              aluCout_i,
   input  logic              aluOverflow_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] ir_o,
   output logic [DATA_W-1:0] acc_o,
   output logic [DATA_W-1:0] mdr_o,
   output logic              z_o,
   output logic              c_o,
   output logic              v_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] mdr_q;
   logic              z_q, c_q, v_q;

   // Next PC: restart at zero, sequential increment (wraps silently) or branch target
   always_comb begin
      pc_d = pc_q;
      case (pcSel_i)
         PC_ZERO: pc_d = '0;
         PC_INC:  pc_d = pc_q + ADDR_W'(1);
         PC_JUMP: pc_d = jumpAddr_i;
         default: pc_d = pc_q;
      endcase
   end

   // Next accumulator: memory load, immediate or ALU result
   always_comb begin
      acc_d = memRdata_i;
      case (accSel_i)
         ACC_MEM: acc_d = memRdata_i;
         ACC_IMM: acc_d = immValue_i;
         ACC_ALU: acc_d = aluResult_i;
         default: acc_d = memRdata_i;
      endcase
   end

   // Register updates; Z follows every accumulator load, C/V only ALU write-backs
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= '0;
         ir_q  <= '0;
         acc_q <= '0;
         mdr_q <= '0;
         z_q   <= 1'b0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
      end else begin
         if (pcLoad_i) begin
            pc_q <= pc_d;
         end
         if (irLoad_i) begin
            ir_q <= memRdata_i;
         end
         if (mdrLoad_i) begin
            mdr_q <= memRdata_i;
         end
         if (accLoad_i) begin
            acc_q <= acc_d;
            z_q   <= (acc_d == '0);
         end
         if (flagsLoad_i) begin
            c_q <= aluCout_i;
            v_q <= aluOverflow_i;
         end
      end
   end

   assign pc_o  = pc_q;
   assign ir_o  = ir_q;
   assign acc_o = acc_q;
   assign mdr_o = mdr_q;
   assign z_o   = z_q;
   assign c_o   = c_q;
   assign v_o   = v_q;

endmodule

// File: rtl/ctrl_sequencer.sv
// Fetch/decode/execute control FSM. Drives the memory handshake and the
// external ALU, and steers the datapath register load enables.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int OPC_W  = 4
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [2:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_cout,
   input  logic              alu_overflow,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] acc
);

   state_e            state_q, state_d;
   logic              err_q, err_d;

   pc_sel_e           pcSel;
   acc_sel_e          accSel;
   logic              pcLoad, irLoad, mdrLoad, accLoad, flagsLoad;

   logic [DATA_W-1:0] irVal, mdrVal;
   logic              zFlag, cFlag, unusedOverflow;
   logic [MAX_W-1:0]  opcode;
   logic [ADDR_W-1:0] operand;

   ctrl_datapath #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) uDatapath (
      .clk          (clk),
      .rst          (rst),
      .pcLoad_i     (pcLoad),
      .pcSel_i      (pcSel),
      .jumpAddr_i   (operand),
      .irLoad_i     (irLoad),
      .mdrLoad_i    (mdrLoad),
      .accLoad_i    (accLoad),
      .accSel_i     (accSel),
      .flagsLoad_i  (flagsLoad),
      .memRdata_i   (mem_rdata),
      .immValue_i   (DATA_W'(operand)),
      .aluResult_i  (alu_result),
      .aluCout_i    (alu_cout),
      .aluOverflow_i(alu_overflow),
      .pc_o         (pc),
      .ir_o         (irVal),
      .acc_o        (acc),
      .mdr_o        (mdrVal),
      .z_o          (zFlag),
      .c_o          (cFlag),
      .v_o          (unusedOverflow)
   );

   // Split the held instruction into its opcode and operand fields
   always_comb begin
      opcode  = instrOpcode(MAX_W'(irVal), DATA_W, OPC_W);
      operand = ADDR_W'(instrOperand(MAX_W'(irVal), ADDR_W));
   end

   // State and sticky error registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic, datapath enables and bus outputs; request signals depend
   // only on registered state so they hold steady across memory wait cycles
   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      pcLoad    = 1'b0;
      pcSel     = PC_INC;
      irLoad    = 1'b0;
      mdrLoad   = 1'b0;
      accLoad   = 1'b0;
      accSel    = ACC_MEM;
      flagsLoad = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_op    = '0;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               pcLoad  = 1'b1;
               pcSel   = PC_ZERO;
               err_d   = 1'b0;
               state_d = ST_FETCH;
            end
         end

         ST_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            if (mem_valid) begin
               irLoad  = 1'b1;
               pcLoad  = 1'b1;
               pcSel   = PC_INC;
               state_d = ST_DECODE;
            end
         end

         ST_DECODE: begin
            state_d = ST_FETCH;
            case (opcode)
               MAX_W'(OP_NOP): begin
               end
               MAX_W'(OP_LDI): begin
                  accLoad = 1'b1;
                  accSel  = ACC_IMM;
               end
               MAX_W'(OP_JMP): begin
                  pcLoad = 1'b1;
                  pcSel  = PC_JUMP;
               end
               MAX_W'(OP_JZ): begin
                  pcLoad = zFlag;
                  pcSel  = PC_JUMP;
               end
               MAX_W'(OP_JC): begin
                  pcLoad = cFlag;
                  pcSel  = PC_JUMP;
               end
               MAX_W'(OP_HLT): begin
                  state_d = ST_HALT;
               end
               MAX_W'(OP_LDA), MAX_W'(OP_STA), MAX_W'(OP_ADD), MAX_W'(OP_SUB),
               MAX_W'(OP_AND), MAX_W'(OP_OR),  MAX_W'(OP_XOR): begin
                  state_d = ST_EXEC;
               end
               default: begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end
            endcase
         end

         ST_EXEC: begin
            mem_req  = 1'b1;
            mem_addr = operand;
            if (opcode == MAX_W'(OP_STA)) begin
               mem_we    = 1'b1;
               mem_wdata = acc;
            end
            if (mem_valid) begin
               if (opcode == MAX_W'(OP_STA)) begin
                  state_d = ST_FETCH;
               end else if (opcode == MAX_W'(OP_LDA)) begin
                  accLoad = 1'b1;
                  accSel  = ACC_MEM;
                  state_d = ST_FETCH;
               end else begin
                  mdrLoad = 1'b1;
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            alu_a     = acc;
            alu_b     = mdrVal;
            alu_op    = aluOpFor(opcode);
            accLoad   = 1'b1;
            accSel    = ACC_ALU;
            flagsLoad = 1'b1;
            state_d   = ST_FETCH;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
   assign halted = (state_q == ST_HALT);
   assign err    = err_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: behavioural memory with configurable
// wait states, behavioural ALU, and a bus-transaction scoreboard.
module tb_ctrl_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mem_req, mem_we, mem_valid;
   logic [3:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic       alu_cout, alu_overflow;
   logic       busy, halted, err;
   logic [3:0] pc;
   logic [7:0] acc;

   logic [7:0] mem [16];
   int         waitCnt = 0;
   int         waitCfg = 0;
   logic       progWe;
   logic [3:0] progAddr;
   logic [7:0] progData;

   int testCount = 0;
   int failCount = 0;

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] data;
   } txn_t;
   txn_t expQ[$];
   txn_t expT;

   logic       prevHold = 1'b0;
   logic       prevWe;
   logic [3:0] prevAddr;
   logic [7:0] prevData;

   ctrl_sequencer #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_valid   (mem_valid),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_op      (alu_op),
      .alu_result  (alu_result),
      .alu_cout    (alu_cout),
      .alu_overflow(alu_overflow),
      .busy        (busy),
      .halted      (halted),
      .err         (err),
      .pc          (pc),
      .acc         (acc)
   );

   always #5 clk = ~clk;

   // Behavioural combinational ALU
   always_comb begin
      logic [8:0] sum;
      sum          = 9'd0;
      alu_result   = 8'd0;
      alu_cout     = 1'b0;
      alu_overflow = 1'b0;
      case (alu_op)
         3'd0: begin
            sum          = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result   = sum[7:0];
            alu_cout     = sum[8];
            alu_overflow = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
         end
         3'd1: begin
            sum          = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
            alu_result   = sum[7:0];
            alu_cout     = sum[8];
            alu_overflow = (alu_a[7] != alu_b[7]) && (sum[7] != alu_a[7]);
         end
         3'd2: alu_result = alu_a & alu_b;
         3'd3: alu_result = alu_a | alu_b;
         3'd4: alu_result = alu_a ^ alu_b;
         default: alu_result = 8'd0;
      endcase
   end

   // Behavioural memory: waitCfg idle cycles before each acknowledge
   assign mem_valid = mem_req && (waitCnt == waitCfg);
   assign mem_rdata = mem[mem_addr];

   always @(posedge clk) begin
      if (progWe) begin
         mem[progAddr] <= progData;
      end else if (mem_req && mem_valid && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      if (!mem_req || mem_valid) begin
         waitCnt <= 0;
      end else begin
         waitCnt <= waitCnt + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: request hold across waits, and each completed access against the scoreboard
   always @(negedge clk) begin
      if (rst) begin
         prevHold <= 1'b0;
      end else begin
         if (prevHold) begin
            checkOutput("reqHeld", 32'(mem_req), 32'd1);
            checkOutput("reqStable", 32'({mem_we, mem_addr, mem_wdata}),
                        32'({prevWe, prevAddr, prevData}));
         end
         if (mem_req && mem_valid) begin
            if (expQ.size() == 0) begin
               testCount++;
               failCount++;
               $display("[TB] FAIL unexpectedTxn: actual we=%0b addr=0x%0h, required no access",
                        mem_we, mem_addr);
            end else begin
               expT = expQ.pop_front();
               checkOutput("txnWe", 32'(mem_we), 32'(expT.we));
               checkOutput("txnAddr", 32'(mem_addr), 32'(expT.addr));
               if (expT.we) begin
                  checkOutput("txnWdata", 32'(mem_wdata), 32'(expT.data));
               end
            end
         end
         prevHold <= mem_req && !mem_valid;
         prevWe   <= mem_we;
         prevAddr <= mem_addr;
         prevData <= mem_wdata;
      end
   end

   task automatic expectRead(input logic [3:0] addr);
      txn_t t;
      t.we   = 1'b0;
      t.addr = addr;
      t.data = 8'h00;
      expQ.push_back(t);
   endtask

   task automatic expectWrite(input logic [3:0] addr, input logic [7:0] data);
      txn_t t;
      t.we   = 1'b1;
      t.addr = addr;
      t.data = data;
      expQ.push_back(t);
   endtask

   task automatic loadWord(input logic [3:0] addr, input logic [7:0] data);
      progAddr = addr;
      progData = data;
      progWe   = 1'b1;
      @(posedge clk);
      #1;
      progWe   = 1'b0;
   endtask

   task automatic clearMem();
      for (int i = 0; i < 16; i++) begin
         loadWord(4'(i), 8'h00);
      end
   endtask

   // Pulse start, then count cycles from the start edge until HALT
   task automatic applyStimulus(output int cycles);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("startErrClear", 32'(err), 32'd0);
      checkOutput("startBusy", 32'(busy), 32'd1);
      cycles = 0;
      while (!halted && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      checkOutput("haltReached", 32'(halted), 32'd1);
   endtask

   task automatic loadAddProgram();
      clearMem();
      loadWord(4'h0, 8'hB5);
      loadWord(4'h1, 8'h3E);
      loadWord(4'h2, 8'h2F);
      loadWord(4'h3, 8'hF0);
      loadWord(4'hE, 8'h03);
      expectRead(4'h0);
      expectRead(4'h1);
      expectRead(4'hE);
      expectRead(4'h2);
      expectWrite(4'hF, 8'h08);
      expectRead(4'h3);
   endtask

   initial begin
      int cycles;
      int found;
      rst      = 1'b1;
      start    = 1'b0;
      progWe   = 1'b0;
      progAddr = 4'h0;
      progData = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstCtrlOutputs", 32'({mem_req, mem_we, busy, halted, err}), 32'd0);
      checkOutput("rstMemAddr", 32'(mem_addr), 32'd0);
      checkOutput("rstMemWdata", 32'(mem_wdata), 32'd0);
      checkOutput("rstAluOutputs", 32'({alu_op, alu_a, alu_b}), 32'd0);
      checkOutput("rstPc", 32'(pc), 32'd0);
      checkOutput("rstAcc", 32'(acc), 32'd0);
      rst = 1'b0;

      // LDI 5; ADD [E]; STA [F]; HLT with zero-wait memory
      $display("[TB] add/store program, zero wait");
      waitCfg = 0;
      loadAddProgram();
      applyStimulus(cycles);
      checkOutput("addCycles", 32'(cycles), 32'd11);
      checkOutput("addErr", 32'(err), 32'd0);
      checkOutput("addPc", 32'(pc), 32'd4);
      checkOutput("addAcc", 32'(acc), 32'h08);
      checkOutput("addMemF", 32'(mem[15]), 32'h08);
      checkOutput("addDrain", 32'(expQ.size()), 32'd0);

      // Same program, two wait cycles on every access
      $display("[TB] add/store program, two wait states");
      waitCfg = 2;
      loadAddProgram();
      applyStimulus(cycles);
      checkOutput("waitCycles", 32'(cycles), 32'd23);
      checkOutput("waitPc", 32'(pc), 32'd4);
      checkOutput("waitAcc", 32'(acc), 32'h08);
      checkOutput("waitMemF", 32'(mem[15]), 32'h08);
      checkOutput("waitDrain", 32'(expQ.size()), 32'd0);

      // JZ taken after LDI 0, not taken after LDI 1
      $display("[TB] conditional branch on Z");
      waitCfg = 0;
      clearMem();
      loadWord(4'h0, 8'hB0);
      loadWord(4'h1, 8'h96);
      loadWord(4'h2, 8'hF0);
      loadWord(4'h6, 8'hB1);
      loadWord(4'h7, 8'h9C);
      loadWord(4'h8, 8'hF0);
      expectRead(4'h0);
      expectRead(4'h1);
      expectRead(4'h6);
      expectRead(4'h7);
      expectRead(4'h8);
      applyStimulus(cycles);
      checkOutput("jzPc", 32'(pc), 32'd9);
      checkOutput("jzAcc", 32'(acc), 32'h01);
      checkOutput("jzDrain", 32'(expQ.size()), 32'd0);

      // 0xFF + 0x01 wraps to zero with carry; JC then JZ both taken
      $display("[TB] carry and zero from ALU");
      clearMem();
      loadWord(4'h0, 8'h1D);
      loadWord(4'h1, 8'h3E);
      loadWord(4'h2, 8'hA5);
      loadWord(4'h3, 8'hF0);
      loadWord(4'h4, 8'hF0);
      loadWord(4'h5, 8'h2F);
      loadWord(4'h6, 8'h99);
      loadWord(4'h7, 8'hF0);
      loadWord(4'h8, 8'hF0);
      loadWord(4'h9, 8'hF0);
      loadWord(4'hD, 8'hFF);
      loadWord(4'hE, 8'h01);
      loadWord(4'hF, 8'h55);
      expectRead(4'h0);
      expectRead(4'hD);
      expectRead(4'h1);
      expectRead(4'hE);
      expectRead(4'h2);
      expectRead(4'h5);
      expectWrite(4'hF, 8'h00);
      expectRead(4'h6);
      expectRead(4'h9);
      applyStimulus(cycles);
      checkOutput("carryPc", 32'(pc), 32'hA);
      checkOutput("carryAcc", 32'(acc), 32'h00);
      checkOutput("carryMemF", 32'(mem[15]), 32'h00);
      checkOutput("carryDrain", 32'(expQ.size()), 32'd0);

      // SUB, AND, OR, XOR chain: 5A-0F=4B, &33=03, |0F=0F, ^33=3C
      $display("[TB] logic and subtract chain");
      clearMem();
      loadWord(4'h0, 8'h1D);
      loadWord(4'h1, 8'h4E);
      loadWord(4'h2, 8'h5C);
      loadWord(4'h3, 8'h6E);
      loadWord(4'h4, 8'h7C);
      loadWord(4'h5, 8'h2F);
      loadWord(4'h6, 8'hF0);
      loadWord(4'hC, 8'h33);
      loadWord(4'hD, 8'h5A);
      loadWord(4'hE, 8'h0F);
      expectRead(4'h0);
      expectRead(4'hD);
      expectRead(4'h1);
      expectRead(4'hE);
      expectRead(4'h2);
      expectRead(4'hC);
      expectRead(4'h3);
      expectRead(4'hE);
      expectRead(4'h4);
      expectRead(4'hC);
      expectRead(4'h5);
      expectWrite(4'hF, 8'h3C);
      expectRead(4'h6);
      applyStimulus(cycles);
      checkOutput("chainPc", 32'(pc), 32'd7);
      checkOutput("chainAcc", 32'(acc), 32'h3C);
      checkOutput("chainDrain", 32'(expQ.size()), 32'd0);

      // Illegal opcode halts with err; a new start clears it and refetches from 0
      $display("[TB] illegal opcode and restart");
      clearMem();
      loadWord(4'h0, 8'hC0);
      expectRead(4'h0);
      applyStimulus(cycles);
      checkOutput("illegalErr", 32'(err), 32'd1);
      checkOutput("illegalPc", 32'(pc), 32'd1);
      checkOutput("illegalDrain", 32'(expQ.size()), 32'd0);
      loadWord(4'h0, 8'hB3);
      loadWord(4'h1, 8'hF0);
      expectRead(4'h0);
      expectRead(4'h1);
      applyStimulus(cycles);
      checkOutput("restartErr", 32'(err), 32'd0);
      checkOutput("restartAcc", 32'(acc), 32'h03);
      checkOutput("restartPc", 32'(pc), 32'd2);
      checkOutput("restartDrain", 32'(expQ.size()), 32'd0);

      // Reset while an EXEC read is waiting abandons the access
      $display("[TB] reset during waiting read");
      waitCfg = 3;
      clearMem();
      loadWord(4'h0, 8'hB7);
      loadWord(4'h1, 8'h1D);
      expectRead(4'h0);
      expectRead(4'h1);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (mem_req && !mem_we && mem_addr == 4'hD && !mem_valid) begin
            found = 1;
         end else begin
            @(posedge clk);
            #1;
         end
      end
      checkOutput("execWaitSeen", 32'(found), 32'd1);
      checkOutput("preResetAcc", 32'(acc), 32'h07);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("resetMemReq", 32'(mem_req), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetPc", 32'(pc), 32'd0);
      checkOutput("resetAcc", 32'(acc), 32'h00);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetIdleReq", 32'(mem_req), 32'd0);
      checkOutput("resetDrain", 32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multi-cycle fetch/decode/execute controller: next generation of the 8-bit CPU control unit. Owns PC, IR, accumulator, operand register and Z/C/V flags. Drives an external memory over a req/valid handshake and an external combinational ALU. Generalised in data/address width, with wait-state tolerance, conditional branches, halt and illegal-opcode detection.

## Interface
- DATA_W, 8, data and instruction word width; must satisfy DATA_W ≥ OPC_W + ADDR_W
- ADDR_W, 4, memory address width; also PC width
- OPC_W, 4, opcode field width; opcode = instruction[DATA_W-1 -: OPC_W]; operand = instruction[ADDR_W-1:0]

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; starts execution from PC 0 when in IDLE or HALT
- mem_req  out  1  memory request; held until mem_valid
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data (= acc)
- mem_rdata  in  DATA_W  read data; sampled when mem_valid
- mem_valid  in  1  read data valid / write acknowledge; ignored while mem_req=0
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  3  ALU operation
- alu_result  in  DATA_W; alu_cout, alu_overflow  in  1 each
- busy  out  1  state ∉ {IDLE, HALT}
- halted  out  1  state = HALT
- err  out  1  sticky illegal-opcode flag
- pc  out  ADDR_W; acc  out  DATA_W  architectural state visibility

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE/HALT + start: pc←0, err←0, → FETCH. start ignored elsewhere.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_valid: ir←mem_rdata, pc←pc+1 (wraps 2^ADDR_W−1→0 silently), → DECODE.
- DECODE (one cycle):
  - NOP 0x0: no effect, → FETCH.
  - LDI 0xB: acc←zero-extended operand, Z updated, → FETCH.
  - JMP 0x8: pc←operand. JZ 0x9: pc←operand if Z. JC 0xA: pc←operand if C. All → FETCH.
  - HLT 0xF: → HALT.
  - LDA 0x1, STA 0x2, ADD 0x3, SUB 0x4, AND 0x5, OR 0x6, XOR 0x7: → EXEC.
  - Other opcodes: err←1, → HALT.
- EXEC: mem_addr=operand, mem_req=1. STA: mem_we=1, mem_wdata=acc; on mem_valid → FETCH. LDA: on mem_valid acc←mem_rdata, Z updated, → FETCH. ALU ops: on mem_valid mdr←mem_rdata, → WB.
- WB: alu_a=acc, alu_b=mdr, alu_op from opcode (ADD 0, SUB 1, AND 2, OR 3, XOR 4). acc←alu_result; Z←(alu_result==0), C←alu_cout, V←alu_overflow; → FETCH.
- Z is written by LDA, LDI and ALU ops; C and V by ALU ops only.
- When mem_req=0: mem_addr, mem_we and mem_wdata are 0. Outside WB: alu_a, alu_b and alu_op are 0.

## Timing
- Reset: state IDLE; pc, ir, acc, mdr, Z/C/V and err are 0. All outputs are 0.
- Reset mid-transaction wins: mem_req drops the next cycle and the in-flight access is abandoned.
- mem_valid may be asserted combinationally in the same cycle as mem_req (zero wait). Each wait cycle adds one cycle of latency.
- Zero-wait latency, FETCH entry to next FETCH: NOP/LDI/JMP/JZ/JC = 2 cycles; LDA/STA = 3; ALU ops = 4.
- mem_req, mem_we, mem_addr and mem_wdata stay stable from request until the mem_valid cycle inclusive.
- A jump that targets its own address loops indefinitely; this is legal.

## Structure
- Package ctrl_pkg holds:
  - opcode constants
  - ALU op encodings
  - state enum
  - instruction field-slicing helpers (opcode/operand extraction)
- Sub-module ctrl_datapath holds acc, mdr, ir, pc and flags, with load enables driven by the FSM in ctrl_sequencer.

## Test plan
- Program LDI 5; ADD [0xE] (mem[0xE]=3); STA [0xF]; HLT at zero wait → mem[0xF]=8, halted=1 at cycle 11 after start, Z=0.
- Memory inserts 2 wait cycles on every access → same final state; request signals stable throughout each wait.
- LDI 0; JZ 0x6 → pc=6 next fetch. LDI 1; JZ 0x6 → falls through to pc+1.
- ADD with acc=0xFF, mem=0x01 → acc=0x00, Z=1, C=1. JC 0x3 then taken.
- Opcode 0xC → err=1, halted=1. A start pulse clears err and refetches from 0.
- rst asserted during a waiting EXEC read → next cycle mem_req=0, state IDLE, pc=0, acc=0.
